// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_e;
  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;
  localparam int DATA_BITS_MIN = 5;
  localparam int VOTE_LO = -1;
  localparam int VOTE_HI = 1;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO; push into a full FIFO only lands when a pop frees the slot
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign wr = push_i && (!full_o || pop_i);
  assign rd = pop_i && !empty_o;
  assign cnt_d = (wr && !rd) ? cnt_q + 1'b1 : (rd && !wr) ? cnt_q - 1'b1 : cnt_q;
  assign dout_o = empty_o ? '0 : mem_q[rp_q];
  assign level_o = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority vote, error/break/overrun detection and RX FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int RTS_THRESH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic                          rx,
  input  logic [1:0]                    data_bit_num,
  input  logic                          stop_bit_num,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          rts_n,
  output logic                          overrun,
  output logic                          break_det,
  input  logic                          err_clr
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0 = SW'(OVERSAMPLE / 2 + VOTE_LO);
  localparam logic [SW-1:0] S_V1 = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2 = SW'(OVERSAMPLE / 2 + VOTE_HI);
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_prev_q;
  rx_state_e state_q;
  logic [SW-1:0] s_q;
  logic [2:0] idx_q;
  logic [3:0] nbits_q;
  logic [7:0] data_q;
  logic stop2_q, pen_q, ptype_q, v0_q, v1_q, pbit_q, perr_q, ferr_q, stop_idx_q;
  logic push_q, overrun_q, break_q, rts_q;
  rx_entry_t entry_q, head;
  logic vote, decide, brk, ovr_set;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign decide = tick && s_q == S_V2;
  assign vote = maj3(v0_q, v1_q, rx_s);
  // break: all-zero data, zero parity (if any) and a zero first stop bit
  assign brk = state_q == STOP && decide && !stop_idx_q && !vote && data_q == '0 && !(pen_q && pbit_q);
  assign ovr_set = push_q && full && !rd_en;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      rx_prev_q <= 1'b1;
      state_q <= IDLE;
      s_q <= '0;
      idx_q <= '0;
      nbits_q <= 4'(DATA_BITS_MIN);
      data_q <= '0;
      {stop2_q, pen_q, ptype_q, v0_q, v1_q, pbit_q, perr_q, ferr_q, stop_idx_q} <= '0;
      push_q <= 1'b0;
      entry_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
      push_q <= 1'b0;
      if (tick) s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
      if (tick && s_q == S_V0) v0_q <= rx_s;
      if (tick && s_q == S_V1) v1_q <= rx_s;
      case (state_q)
        IDLE: if (rx_prev_q && !rx_s) begin
          state_q <= START;
          s_q <= '0;
          nbits_q <= 4'(data_bit_num) + 4'(DATA_BITS_MIN);
          stop2_q <= stop_bit_num;
          pen_q <= parity_en;
          ptype_q <= parity_type;
          data_q <= '0;
          idx_q <= '0;
          {pbit_q, perr_q, ferr_q, stop_idx_q} <= '0;
        end
        START: if (decide) state_q <= vote ? IDLE : DATA;
        DATA: if (decide) begin
          data_q[idx_q] <= vote;
          idx_q <= idx_q + 1'b1;
          if (idx_q == 3'(nbits_q - 4'd1)) state_q <= pen_q ? PARITY : STOP;
        end
        PARITY: if (decide) begin
          pbit_q <= vote;
          perr_q <= vote != ((^data_q) ^ ptype_q);
          state_q <= STOP;
        end
        STOP: if (decide) begin
          if (brk || stop_idx_q || !stop2_q) begin
            push_q <= 1'b1;
            entry_q.frame_err <= ferr_q | ~vote;
            entry_q.parity_err <= perr_q & ~brk;
            entry_q.data <= data_q;
            state_q <= (ferr_q | ~vote) ? WAIT_IDLE : IDLE;
            s_q <= '0;
          end else begin
            ferr_q <= ~vote;
            stop_idx_q <= 1'b1;
          end
        end
        WAIT_IDLE: if (!rx_s) s_q <= '0; else if (tick && s_q == S_LAST) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      break_q <= 1'b0;
      rts_q <= 1'b0;
    end else begin
      overrun_q <= ovr_set | (overrun_q & ~err_clr);
      break_q <= brk | (break_q & ~err_clr);
      rts_q <= level >= LW'(RTS_THRESH);
    end
  end
  uart_sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(push_q),
    .din_i(entry_q),
    .pop_i(rd_en),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(level)
  );
  assign rd_data = head.data;
  assign rd_parity_err = head.parity_err;
  assign rd_frame_err = head.frame_err;
  assign rts_n = rts_q;
  assign overrun = overrun_q;
  assign break_det = break_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench; serial frames from a reference encoder, FIFO output checked by a monitor
module tb_uart_rx_fifo;
  localparam int OS = 16;
  localparam int DEPTH = 16;
  localparam int THRESH = 12;
  localparam int TDIV = 3;
  localparam int BITC = OS * TDIV;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, rx = 1'b1;
  logic [1:0] data_bit_num = 2'd3;
  logic stop_bit_num = 1'b0, parity_en = 1'b0, parity_type = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] rd_data;
  logic rd_parity_err, rd_frame_err, empty, full, rts_n, overrun, break_det;
  logic [4:0] level;
  int n_chk = 0, n_fail = 0, lvl_prev = 0, cfg_bits = 8;
  logic rd_go = 1'b0, rd_poke = 1'b0, exp_ovr = 1'b0;
  logic cfg_stop2 = 1'b0, cfg_pen = 1'b0, cfg_podd = 1'b0;
  logic [9:0] exp_q[$];

  uart_rx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .RTS_THRESH(THRESH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
    .parity_en(parity_en), .parity_type(parity_type),
    .rd_en(rd_en), .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .empty(empty), .full(full), .level(level), .rts_n(rts_n),
    .overrun(overrun), .break_det(break_det), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    clks(BITC);
  endtask

  task automatic set_cfg(input int bits, input logic stop2, input logic pen, input logic podd);
    cfg_bits = bits;
    cfg_stop2 = stop2;
    cfg_pen = pen;
    cfg_podd = podd;
    data_bit_num = 2'(bits - 5);
    stop_bit_num = stop2;
    parity_en = pen;
    parity_type = podd;
  endtask

  // Reference encoder: builds the line waveform and predicts the FIFO entry from the framing rules
  task automatic send_frame(input logic [7:0] d, input logic inv_par, input logic bad_stop, input logic scramble);
    logic [7:0] dm;
    logic p, s1, s2;
    dm = d & 8'((1 << cfg_bits) - 1);
    p = (^dm) ^ cfg_podd ^ inv_par;
    s1 = !(bad_stop && !cfg_stop2);
    s2 = !bad_stop;
    if (rd_go || exp_q.size() < DEPTH) exp_q.push_back({bad_stop, inv_par & cfg_pen, dm});
    else exp_ovr = 1'b1;
    rx = 1'b0;
    clks(8);
    if (scramble) begin
      data_bit_num = 2'($urandom);
      stop_bit_num = 1'($urandom);
      parity_en = 1'($urandom);
      parity_type = 1'($urandom);
    end
    clks(BITC - 8);
    for (int i = 0; i < cfg_bits; i++) bit_out(dm[i]);
    if (cfg_pen) bit_out(p);
    bit_out(s1);
    if (cfg_stop2) bit_out(s2);
    set_cfg(cfg_bits, cfg_stop2, cfg_pen, cfg_podd);
    bit_out(1'b1);
    bit_out(1'b1);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 20 * BITC; i++) begin
      if (empty) break;
      clks(1);
    end
    check("wait_empty", empty, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " empty"}, empty, 1);
    check({tag, " full"}, full, 0);
    check({tag, " level"}, level, 0);
    check({tag, " rd_data"}, rd_data, 0);
    check({tag, " rd_parity_err"}, rd_parity_err, 0);
    check({tag, " rd_frame_err"}, rd_frame_err, 0);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " break_det"}, break_det, 0);
    check({tag, " rts_n"}, rts_n, 0);
  endtask

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c = (c + 1) % TDIV;
      tick = (c == 0);
    end
  end

  // Monitor: pops the DUT head against the scoreboard and checks rts_n lags level by one clk
  initial forever begin
    @(posedge clk);
    #1;
    rd_en = rd_poke;
    if (rst_n) begin
      check("rts_n", rts_n, lvl_prev >= THRESH);
      if (rd_go && !empty) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected entry: got 0x%0h, expected none", {rd_frame_err, rd_parity_err, rd_data});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("rx entry", {rd_frame_err, rd_parity_err, rd_data}, e);
        end
        rd_en = 1'b1;
      end
    end
    lvl_prev = level;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cfg(8, 0, 0, 0);
    clks(4);
    rst_n = 1'b1;
    clks(1);
    check_reset("reset");
    send_frame(8'hA5, 0, 0, 0);
    check("8N1 level", level, 1);
    check("8N1 rd_data", rd_data, 8'hA5);
    check("8N1 flags", {rd_parity_err, rd_frame_err}, 0);
    rd_go = 1'b1;
    wait_empty();
    rd_poke = 1'b1;
    clks(1);
    rd_poke = 1'b0;
    clks(2);
    check("pop on empty level", level, 0);
    check("pop on empty empty", empty, 1);
    set_cfg(7, 0, 1, 0);
    send_frame(8'h55, 1, 0, 0);
    wait_empty();
    set_cfg(8, 0, 0, 0);
    rx = 1'b0;
    clks(4 * TDIV);
    rx = 1'b1;
    clks(3 * BITC);
    check("glitch level", level, 0);
    send_frame(8'h5A, 0, 0, 0);
    wait_empty();
    rd_go = 1'b0;
    exp_ovr = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      send_frame(8'(k), 0, 0, 0);
      check("fill level", level, exp_q.size());
      check("fill rts_n", rts_n, k >= THRESH);
      check("fill overrun", overrun, exp_ovr);
    end
    check("fill full", full, 1);
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    clks(1);
    check("err_clr overrun", overrun, 0);
    rd_go = 1'b1;
    wait_empty();
    set_cfg(6, 1, 1, 1);
    send_frame(8'h2A, 0, 1, 0);
    send_frame(8'h15, 0, 0, 0);
    wait_empty();
    set_cfg(8, 0, 0, 0);
    exp_q.push_back(10'h200);
    rx = 1'b0;
    clks(12 * BITC);
    rx = 1'b1;
    clks(2 * BITC);
    check("break_det", break_det, 1);
    send_frame(8'h3C, 0, 0, 0);
    wait_empty();
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    clks(1);
    check("err_clr break_det", break_det, 0);
    repeat (24) begin
      logic [7:0] d, dm;
      logic inv, bad;
      set_cfg($urandom_range(5, 8), 1'($urandom), 1'($urandom), 1'($urandom));
      d = 8'($urandom);
      dm = d & 8'((1 << cfg_bits) - 1);
      inv = cfg_pen && ($urandom_range(0, 3) == 0);
      bad = (dm != 0) && ($urandom_range(0, 3) == 0);
      send_frame(d, inv, bad, 1);
    end
    wait_empty();
    check("scoreboard drained", exp_q.size(), 0);
    check("random break_det", break_det, 0);
    rd_go = 1'b0;
    set_cfg(8, 0, 0, 0);
    send_frame(8'hC3, 0, 0, 0);
    check("pre-reset level", level, 1);
    rx = 1'b0;
    clks(3 * BITC);
    rst_n = 1'b0;
    rx = 1'b1;
    exp_q.delete();
    clks(2);
    rst_n = 1'b1;
    clks(1);
    check_reset("mid-frame reset");
    clks(3 * BITC);
    check("no push after reset", level, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
